// File: rtl/lsu_mem_ctrl.sv
// Load/store unit front end for a word-organised, big-endian data RAM without byte enables.
// Sub-word stores run as a two-cycle read-modify-write; misaligned accesses are reported, not executed.
module lsu_mem_ctrl #(
  parameter int ADDR_W = 17,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [2:0]        req_op,
  input  logic [31:0]       req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              resp_valid,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              resp_err,
  output logic [31:0]       resp_badaddr,
  output logic              ram_ce,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata
);

  localparam logic [2:0] OP_LB  = 3'd0;
  localparam logic [2:0] OP_LBU = 3'd1;
  localparam logic [2:0] OP_LH  = 3'd2;
  localparam logic [2:0] OP_LHU = 3'd3;
  localparam logic [2:0] OP_LW  = 3'd4;
  localparam logic [2:0] OP_SB  = 3'd5;
  localparam logic [2:0] OP_SH  = 3'd6;
  localparam logic [2:0] OP_SW  = 3'd7;

  typedef enum logic {
    IDLE   = 1'b0,
    RMW_WR = 1'b1
  } state_t;

  state_t            state_r;
  state_t            state_s;
  logic [31:0]       merge_r;
  logic [ADDR_W-1:0] addr_r;
  logic              resp_valid_r;
  logic [31:0]       resp_rdata_r;
  logic              resp_err_r;
  logic [31:0]       resp_badaddr_r;

  logic              accept_s;
  logic              misalign_s;
  logic              is_rmw_s;
  logic              is_load_s;

  function automatic logic misaligned_f(input logic [2:0] op, input logic [1:0] off);
    logic bad;
    case (op)
      OP_LH, OP_LHU, OP_SH: bad = off[0];
      OP_LW, OP_SW:         bad = (off != 2'b00);
      default:              bad = 1'b0;
    endcase
    return bad;
  endfunction

  // Offset 0 is the most significant lane (big-endian).
  function automatic logic [7:0] byte_lane_f(input logic [31:0] word, input logic [1:0] off);
    logic [7:0] b;
    case (off)
      2'b00:   b = word[31:24];
      2'b01:   b = word[23:16];
      2'b10:   b = word[15:8];
      2'b11:   b = word[7:0];
      default: b = 8'h00;
    endcase
    return b;
  endfunction

  function automatic logic [31:0] load_extract_f(input logic [2:0] op, input logic [1:0] off,
                                                 input logic [31:0] word);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    b = byte_lane_f(word, off);
    h = off[1] ? word[15:0] : word[31:16];
    case (op)
      OP_LB:   r = {{24{b[7]}}, b};
      OP_LBU:  r = {24'h000000, b};
      OP_LH:   r = {{16{h[15]}}, h};
      OP_LHU:  r = {16'h0000, h};
      OP_LW:   r = word;
      default: r = 32'h00000000;
    endcase
    return r;
  endfunction

  function automatic logic [31:0] merge_f(input logic [2:0] op, input logic [1:0] off,
                                          input logic [31:0] word, input logic [31:0] wd);
    logic [31:0] m;
    m = word;
    if (op == OP_SB) begin
      case (off)
        2'b00:   m[31:24] = wd[7:0];
        2'b01:   m[23:16] = wd[7:0];
        2'b10:   m[15:8]  = wd[7:0];
        2'b11:   m[7:0]   = wd[7:0];
        default: m = word;
      endcase
    end else if (off[1]) begin
      m[15:0] = wd[15:0];
    end else begin
      m[31:16] = wd[15:0];
    end
    return m;
  endfunction

  assign req_ready  = (state_r == IDLE);
  assign accept_s   = req_valid && req_ready;
  assign misalign_s = misaligned_f(req_op, req_addr[1:0]);
  assign is_rmw_s   = (req_op == OP_SB) || (req_op == OP_SH);
  assign is_load_s  = (req_op <= OP_LW);

  // Next state and the combinational RAM drive.
  always_comb begin
    state_s   = state_r;
    ram_ce    = 1'b0;
    ram_we    = 1'b0;
    ram_addr  = {ADDR_W{1'b0}};
    ram_wdata = {DATA_W{1'b0}};
    case (state_r)
      IDLE: begin
        if (accept_s && !misalign_s) begin
          ram_ce   = 1'b1;
          ram_addr = req_addr[ADDR_W+1:2];
          if (req_op == OP_SW) begin
            ram_we    = 1'b1;
            ram_wdata = req_wdata;
          end else if (is_rmw_s) begin
            state_s = RMW_WR;
          end else begin
            ram_we = 1'b0;
          end
        end else begin
          state_s = IDLE;
        end
      end
      RMW_WR: begin
        ram_ce    = 1'b1;
        ram_we    = 1'b1;
        ram_addr  = addr_r;
        ram_wdata = merge_r;
        state_s   = IDLE;
      end
      default: state_s = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Captures the merged word and its address during the read phase of a sub-word store.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      merge_r <= 32'h00000000;
      addr_r  <= {ADDR_W{1'b0}};
    end else if (accept_s && is_rmw_s && !misalign_s) begin
      merge_r <= merge_f(req_op, req_addr[1:0], ram_rdata, req_wdata);
      addr_r  <= req_addr[ADDR_W+1:2];
    end else begin
      merge_r <= merge_r;
      addr_r  <= addr_r;
    end
  end

  // Registered response; an RMW responds after its write cycle, everything else one cycle after accept.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      resp_valid_r   <= 1'b0;
      resp_rdata_r   <= 32'h00000000;
      resp_err_r     <= 1'b0;
      resp_badaddr_r <= 32'h00000000;
    end else if (state_r == RMW_WR) begin
      resp_valid_r   <= 1'b1;
      resp_rdata_r   <= 32'h00000000;
      resp_err_r     <= 1'b0;
      resp_badaddr_r <= 32'h00000000;
    end else if (accept_s && misalign_s) begin
      resp_valid_r   <= 1'b1;
      resp_rdata_r   <= 32'h00000000;
      resp_err_r     <= 1'b1;
      resp_badaddr_r <= req_addr;
    end else if (accept_s && !is_rmw_s) begin
      resp_valid_r   <= 1'b1;
      resp_rdata_r   <= is_load_s ? load_extract_f(req_op, req_addr[1:0], ram_rdata) : 32'h00000000;
      resp_err_r     <= 1'b0;
      resp_badaddr_r <= 32'h00000000;
    end else begin
      resp_valid_r   <= 1'b0;
      resp_rdata_r   <= resp_rdata_r;
      resp_err_r     <= resp_err_r;
      resp_badaddr_r <= resp_badaddr_r;
    end
  end

  assign resp_valid   = resp_valid_r;
  assign resp_rdata   = resp_rdata_r;
  assign resp_err     = resp_err_r;
  assign resp_badaddr = resp_badaddr_r;

endmodule
